// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer SPRAM arbiter: SPI host, encoder write stream and
// entropy-decoder read stream share one RAM access per clock.
module fb_port_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 8,
    parameter int ENC_BURST = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W:0]   buf_len,
    input  logic              frame_start,
    input  logic              dec_start,
    input  logic              spi_req,
    input  logic              spi_we,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_wdata,
    output logic              spi_gnt,
    output logic [DATA_W-1:0] spi_rdata,
    output logic              spi_rvalid,
    input  logic              enc_req,
    input  logic [DATA_W-1:0] enc_wdata,
    output logic              enc_gnt,
    output logic              enc_full,
    output logic              enc_ovf,
    input  logic              dec_req,
    output logic              dec_gnt,
    output logic [DATA_W-1:0] dec_rdata,
    output logic              dec_rvalid,
    output logic              dec_empty,
    output logic [ADDR_W:0]   wr_count,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int BW = $clog2(ENC_BURST + 1);
    localparam logic [BW-1:0]   BURST_MAX = BW'(ENC_BURST);
    localparam logic [ADDR_W:0] CAPACITY  = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_SPI,
        OWN_DEC
    } owner_t;

    logic [ADDR_W:0] wptr;
    logic [ADDR_W:0] rptr;
    logic [ADDR_W:0] len_q;
    logic [BW-1:0]   burst_cnt;
    logic            enc_elig;
    logic            dec_elig;
    owner_t          tag_issue;
    owner_t          tag_data;
    owner_t          tag_next;
    logic              ram_ce_next;
    logic              ram_we_next;
    logic [ADDR_W-1:0] ram_addr_next;
    logic [DATA_W-1:0] ram_wdata_next;

    // rptr >= wptr also covers a new frame restarting wptr under an active reader
    assign enc_full  = (wptr == len_q);
    assign dec_empty = (rptr >= wptr);
    assign wr_count  = wptr;
    assign enc_elig  = enc_req & ~enc_full & ~frame_start;
    assign dec_elig  = dec_req & ~dec_empty & ~dec_start;

    always_comb begin
        spi_gnt = spi_req;
        enc_gnt = 1'b0;
        dec_gnt = 1'b0;
        if (!spi_req) begin
            if (enc_elig && (!dec_elig || burst_cnt < BURST_MAX)) begin
                enc_gnt = 1'b1;
            end else if (dec_elig) begin
                dec_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        ram_ce_next    = spi_gnt | enc_gnt | dec_gnt;
        ram_we_next    = 1'b0;
        ram_addr_next  = '0;
        ram_wdata_next = '0;
        tag_next       = OWN_NONE;
        if (spi_gnt) begin
            ram_we_next   = spi_we;
            ram_addr_next = spi_addr;
            if (spi_we) begin
                ram_wdata_next = spi_wdata;
            end else begin
                tag_next = OWN_SPI;
            end
        end else if (enc_gnt) begin
            ram_we_next    = 1'b1;
            ram_addr_next  = wptr[ADDR_W-1:0];
            ram_wdata_next = enc_wdata;
        end else if (dec_gnt) begin
            ram_addr_next = rptr[ADDR_W-1:0];
            tag_next      = OWN_DEC;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr      <= '0;
            rptr      <= '0;
            len_q     <= '0;
            enc_ovf   <= 1'b0;
            burst_cnt <= '0;
        end else begin
            if (frame_start) begin
                wptr    <= '0;
                enc_ovf <= 1'b0;
                len_q   <= (buf_len > CAPACITY) ? CAPACITY : buf_len;
            end else begin
                if (enc_gnt) begin
                    wptr <= wptr + 1'b1;
                end
                if (enc_req && enc_full) begin
                    enc_ovf <= 1'b1;
                end
            end
            if (dec_start) begin
                rptr <= '0;
            end else if (dec_gnt) begin
                rptr <= rptr + 1'b1;
            end
            // Burst count holds across SPI-stolen cycles so the decoder's turn is not lost
            if (dec_gnt || !dec_elig) begin
                burst_cnt <= '0;
            end else if (enc_gnt) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            tag_issue <= OWN_NONE;
            tag_data  <= OWN_NONE;
        end else begin
            ram_ce    <= ram_ce_next;
            ram_we    <= ram_we_next;
            ram_addr  <= ram_addr_next;
            ram_wdata <= ram_wdata_next;
            tag_issue <= tag_next;
            tag_data  <= tag_issue;
        end
    end

    // Read data comes straight from the RAM in the cycle its owner tag matures
    assign spi_rvalid = (tag_data == OWN_SPI);
    assign dec_rvalid = (tag_data == OWN_DEC);
    assign spi_rdata  = spi_rvalid ? ram_rdata : '0;
    assign dec_rdata  = dec_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed table-driven bench for fb_port_arbiter with a synchronous SPRAM model.
module tb_fb_port_arbiter;

    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 8;
    localparam int ENC_BURST = 4;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W:0]   buf_len = '0;
    logic              frame_start = 1'b0;
    logic              dec_start = 1'b0;
    logic              spi_req = 1'b0;
    logic              spi_we = 1'b0;
    logic [ADDR_W-1:0] spi_addr = '0;
    logic [DATA_W-1:0] spi_wdata = '0;
    logic              spi_gnt;
    logic [DATA_W-1:0] spi_rdata;
    logic              spi_rvalid;
    logic              enc_req = 1'b0;
    logic [DATA_W-1:0] enc_wdata = '0;
    logic              enc_gnt;
    logic              enc_full;
    logic              enc_ovf;
    logic              dec_req = 1'b0;
    logic              dec_gnt;
    logic [DATA_W-1:0] dec_rdata;
    logic              dec_rvalid;
    logic              dec_empty;
    logic [ADDR_W:0]   wr_count;
    logic              ram_ce;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;

    int total = 0;
    int bad = 0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    fb_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ENC_BURST(ENC_BURST)) dut (
        .clock(clock), .reset_n(reset_n), .buf_len(buf_len),
        .frame_start(frame_start), .dec_start(dec_start),
        .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
        .spi_gnt(spi_gnt), .spi_rdata(spi_rdata), .spi_rvalid(spi_rvalid),
        .enc_req(enc_req), .enc_wdata(enc_wdata), .enc_gnt(enc_gnt),
        .enc_full(enc_full), .enc_ovf(enc_ovf),
        .dec_req(dec_req), .dec_gnt(dec_gnt), .dec_rdata(dec_rdata),
        .dec_rvalid(dec_rvalid), .dec_empty(dec_empty), .wr_count(wr_count),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clock = ~clock;

    // SPRAM model: write-or-read per enabled cycle, read data one clock later
    always @(posedge clock) begin
        if (ram_ce) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    typedef struct {
        logic fs, ds, sreq, swe;
        logic [13:0] saddr;
        logic [7:0]  swdata;
        logic        ereq;
        logic [7:0]  ewdata;
        logic        dreq;
        logic [14:0] blen;
        logic [2:0]  gnt;
        logic        full, ovf, empty;
        logic [14:0] wr;
        logic        ce, we;
        logic [13:0] addr;
        logic [7:0]  wdata;
        logic        srv, drv;
        logic [7:0]  rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clock);
        frame_start = v.fs;
        dec_start   = v.ds;
        spi_req     = v.sreq;
        spi_we      = v.swe;
        spi_addr    = v.saddr;
        spi_wdata   = v.swdata;
        enc_req     = v.ereq;
        enc_wdata   = v.ewdata;
        dec_req     = v.dreq;
        buf_len     = v.blen;
        #1;
    endtask

    task automatic drive(input logic fs, input logic ds, input logic ereq, input logic dreq,
                         input logic [14:0] blen);
        vec_t v;
        v = '{0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0};
        v.fs = fs; v.ds = ds; v.ereq = ereq; v.dreq = dreq; v.blen = blen;
        v.ewdata = 8'hC0;
        apply_stimulus(v);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // fields: fs ds sreq swe saddr swdata ereq ewdata dreq blen | gnt{s,e,d} full ovf empty wr ce we addr wdata srv drv rdata
        // capacity fill, buf_len=4, enc_req held 6 cycles
        vecs.push_back('{1,0,0,0,0,0,      0,0,    0,4,  3'b000,1,0,1,0,  0,0,0,0,          0,0,0});
        vecs.push_back('{0,0,0,0,0,0,      1,'hA0, 0,0,  3'b010,0,0,1,0,  0,0,0,0,          0,0,0});
        vecs.push_back('{0,0,0,0,0,0,      1,'hA1, 0,0,  3'b010,0,0,0,1,  1,1,0,'hA0,       0,0,0});
        vecs.push_back('{0,0,0,0,0,0,      1,'hA2, 0,0,  3'b010,0,0,0,2,  1,1,1,'hA1,       0,0,0});
        vecs.push_back('{0,0,0,0,0,0,      1,'hA3, 0,0,  3'b010,0,0,0,3,  1,1,2,'hA2,       0,0,0});
        vecs.push_back('{0,0,0,0,0,0,      1,'hA4, 0,0,  3'b000,1,0,0,4,  1,1,3,'hA3,       0,0,0});
        vecs.push_back('{0,0,0,0,0,0,      1,'hA5, 0,0,  3'b000,1,1,0,4,  0,0,0,0,          0,0,0});
        // read back in write order, two-cycle latency
        vecs.push_back('{0,1,0,0,0,0,      0,0,    1,0,  3'b000,1,1,0,4,  0,0,0,0,          0,0,0});
        vecs.push_back('{0,0,0,0,0,0,      0,0,    1,0,  3'b001,1,1,0,4,  0,0,0,0,          0,0,0});
        vecs.push_back('{0,0,0,0,0,0,      0,0,    1,0,  3'b001,1,1,0,4,  1,0,0,0,          0,0,0});
        vecs.push_back('{0,0,0,0,0,0,      0,0,    1,0,  3'b001,1,1,0,4,  1,0,1,0,          0,1,'hA0});
        vecs.push_back('{0,0,0,0,0,0,      0,0,    1,0,  3'b001,1,1,0,4,  1,0,2,0,          0,1,'hA1});
        vecs.push_back('{0,0,0,0,0,0,      0,0,    1,0,  3'b000,1,1,1,4,  1,0,3,0,          0,1,'hA2});
        vecs.push_back('{0,0,0,0,0,0,      0,0,    0,0,  3'b000,1,1,1,4,  0,0,0,0,          0,1,'hA3});
        vecs.push_back('{0,0,0,0,0,0,      0,0,    0,0,  3'b000,1,1,1,4,  0,0,0,0,          0,0,0});
        // contention E,E,E,E,D with one SPI read of addr 3 stealing a slot
        vecs.push_back('{1,1,0,0,0,0,      0,0,    0,20, 3'b000,1,1,1,4,  0,0,0,0,          0,0,0});
        vecs.push_back('{0,0,0,0,0,0,      1,'hB0, 1,0,  3'b010,0,0,1,0,  0,0,0,0,          0,0,0});
        vecs.push_back('{0,0,0,0,0,0,      1,'hB1, 1,0,  3'b010,0,0,0,1,  1,1,0,'hB0,       0,0,0});
        vecs.push_back('{0,0,0,0,0,0,      1,'hB2, 1,0,  3'b010,0,0,0,2,  1,1,1,'hB1,       0,0,0});
        vecs.push_back('{0,0,0,0,0,0,      1,'hB3, 1,0,  3'b010,0,0,0,3,  1,1,2,'hB2,       0,0,0});
        vecs.push_back('{0,0,0,0,0,0,      1,'hB4, 1,0,  3'b010,0,0,0,4,  1,1,3,'hB3,       0,0,0});
        vecs.push_back('{0,0,0,0,0,0,      1,'hB5, 1,0,  3'b001,0,0,0,5,  1,1,4,'hB4,       0,0,0});
        vecs.push_back('{0,0,0,0,0,0,      1,'hB5, 1,0,  3'b010,0,0,0,5,  1,0,0,0,          0,0,0});
        vecs.push_back('{0,0,0,0,0,0,      1,'hB6, 1,0,  3'b010,0,0,0,6,  1,1,5,'hB5,       0,1,'hB0});
        vecs.push_back('{0,0,0,0,0,0,      1,'hB7, 1,0,  3'b010,0,0,0,7,  1,1,6,'hB6,       0,0,0});
        vecs.push_back('{0,0,1,0,3,0,      1,'hB8, 1,0,  3'b100,0,0,0,8,  1,1,7,'hB7,       0,0,0});
        vecs.push_back('{0,0,0,0,0,0,      1,'hB8, 1,0,  3'b010,0,0,0,8,  1,0,3,0,          0,0,0});
        vecs.push_back('{0,0,0,0,0,0,      1,'hB9, 1,0,  3'b001,0,0,0,9,  1,1,8,'hB8,       1,0,'hB3});
        vecs.push_back('{0,0,0,0,0,0,      1,'hB9, 1,0,  3'b010,0,0,0,9,  1,0,1,0,          0,0,0});
        vecs.push_back('{0,0,0,0,0,0,      0,0,    0,0,  3'b000,0,0,0,10, 1,1,9,'hB9,       0,1,'hB1});
        // SPI write to the top address, then read it back; pointers stay put
        vecs.push_back('{0,0,1,1,'h3FFF,'h5A, 0,0, 0,0,  3'b100,0,0,0,10, 0,0,0,0,          0,0,0});
        vecs.push_back('{0,0,0,0,0,0,      0,0,    0,0,  3'b000,0,0,0,10, 1,1,'h3FFF,'h5A,  0,0,0});
        vecs.push_back('{0,0,1,0,'h3FFF,0, 0,0,    0,0,  3'b100,0,0,0,10, 0,0,0,0,          0,0,0});
        vecs.push_back('{0,0,0,0,0,0,      0,0,    0,0,  3'b000,0,0,0,10, 1,0,'h3FFF,0,     0,0,0});
        vecs.push_back('{0,0,0,0,0,0,      0,0,    0,0,  3'b000,0,0,0,10, 0,0,0,0,          1,0,'h5A});

        // reset state
        repeat (2) @(negedge clock);
        #1;
        check_output("reset ram_ce", 32'(ram_ce), 0);
        check_output("reset wr_count", 32'(wr_count), 0);
        check_output("reset enc_full", 32'(enc_full), 1);
        check_output("reset dec_empty", 32'(dec_empty), 1);
        check_output("reset enc_ovf", 32'(enc_ovf), 0);
        check_output("reset rvalid", 32'({spi_rvalid, dec_rvalid}), 0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("row%0d gnt", i), 32'({spi_gnt, enc_gnt, dec_gnt}), 32'(vecs[i].gnt));
            check_output($sformatf("row%0d enc_full", i), 32'(enc_full), 32'(vecs[i].full));
            check_output($sformatf("row%0d enc_ovf", i), 32'(enc_ovf), 32'(vecs[i].ovf));
            check_output($sformatf("row%0d dec_empty", i), 32'(dec_empty), 32'(vecs[i].empty));
            check_output($sformatf("row%0d wr_count", i), 32'(wr_count), 32'(vecs[i].wr));
            check_output($sformatf("row%0d ram_ce", i), 32'(ram_ce), 32'(vecs[i].ce));
            check_output($sformatf("row%0d spi_rvalid", i), 32'(spi_rvalid), 32'(vecs[i].srv));
            check_output($sformatf("row%0d dec_rvalid", i), 32'(dec_rvalid), 32'(vecs[i].drv));
            if (vecs[i].ce) begin
                check_output($sformatf("row%0d ram_we", i), 32'(ram_we), 32'(vecs[i].we));
                check_output($sformatf("row%0d ram_addr", i), 32'(ram_addr), 32'(vecs[i].addr));
                if (vecs[i].we)
                    check_output($sformatf("row%0d ram_wdata", i), 32'(ram_wdata), 32'(vecs[i].wdata));
            end
            if (vecs[i].srv)
                check_output($sformatf("row%0d spi_rdata", i), 32'(spi_rdata), 32'(vecs[i].rdata));
            if (vecs[i].drv)
                check_output($sformatf("row%0d dec_rdata", i), 32'(dec_rdata), 32'(vecs[i].rdata));
        end

        // start collision: wptr=2 with ovf set, frame_start alongside enc_req
        drive(1, 0, 0, 0, 2);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        check_output("fill2 enc_gnt at full", 32'(enc_gnt), 0);
        check_output("fill2 enc_full", 32'(enc_full), 1);
        drive(1, 0, 1, 0, 8);
        check_output("collision enc_gnt", 32'(enc_gnt), 0);
        check_output("collision enc_ovf before", 32'(enc_ovf), 1);
        check_output("collision wr_count before", 32'(wr_count), 2);
        drive(0, 0, 0, 0, 0);
        check_output("collision wr_count after", 32'(wr_count), 0);
        check_output("collision enc_ovf after", 32'(enc_ovf), 0);
        check_output("collision enc_full after", 32'(enc_full), 0);

        // reset one cycle after a decoder read grant
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        check_output("rstmid dec_gnt", 32'(dec_gnt), 1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_output("rstmid ram_ce", 32'(ram_ce), 0);
        check_output("rstmid ram_addr", 32'(ram_addr), 0);
        check_output("rstmid dec_gnt", 32'(dec_gnt), 0);
        check_output("rstmid wr_count", 32'(wr_count), 0);
        check_output("rstmid dec_empty", 32'(dec_empty), 1);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 1, 0);
            check_output($sformatf("postrst%0d dec_rvalid", k), 32'(dec_rvalid), 0);
            check_output($sformatf("postrst%0d dec_gnt", k), 32'(dec_gnt), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
